// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, funct, ALU-op and control encodings for the MIPS subset CPU
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_GPIO  = 6'b010000;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [5:0] FN_GPIO_IN  = 6'b000000;
  localparam logic [5:0] FN_GPIO_OUT = 6'b000001;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_NOR   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  localparam logic [1:0] REGSEL_ALU = 2'b00;
  localparam logic [1:0] REGSEL_HI  = 2'b01;
  localparam logic [1:0] REGSEL_LO  = 2'b10;

  localparam logic [1:0] SRC_RT   = 2'b00;
  localparam logic [1:0] SRC_SIMM = 2'b01;
  localparam logic [1:0] SRC_ZIMM = 2'b10;

  localparam logic [4:0] LUI_SHAMT = 5'd16;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] shamt;
    logic       enhilo;
    logic [1:0] regsel;
    logic       regwrite;
    logic       rdrt;
    logic       memwrite;
    logic [1:0] alu_src;
    logic       gpio_out;
    logic       gpio_in;
  } ctrl_t;

  // Bubble: no side effects, ALU left on add so the datapath sees a benign op.
  localparam ctrl_t NOP_CTRL = '{
    alu_op:   ALU_ADD,
    shamt:    5'd0,
    enhilo:   1'b0,
    regsel:   REGSEL_ALU,
    regwrite: 1'b0,
    rdrt:     1'b0,
    memwrite: 1'b0,
    alu_src:  SRC_RT,
    gpio_out: 1'b0,
    gpio_in:  1'b0
  };

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - decode fields in, datapath controls out for the EX-stage decoder
interface control_unit_if;
  logic [5:0] i_type;
  logic [4:0] shamt;
  logic [5:0] function_code;
  logic       stall_FETCH;

  logic [3:0] alu_op;
  logic [4:0] shamt_EX;
  logic       enhilo_EX;
  logic [1:0] regsel_EX;
  logic       regwrite_EX;
  logic       rdrt_EX;
  logic       memwrite_EX;
  logic [1:0] alu_src_EX;
  logic       GPIO_OUT;
  logic       GPIO_IN;

  modport master (
    output i_type, shamt, function_code, stall_FETCH,
    input  alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX,
           rdrt_EX, memwrite_EX, alu_src_EX, GPIO_OUT, GPIO_IN
  );

  modport slave (
    input  i_type, shamt, function_code, stall_FETCH,
    output alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX,
           rdrt_EX, memwrite_EX, alu_src_EX, GPIO_OUT, GPIO_IN
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - combinational EX-stage instruction decoder; rst and stall force a bubble
module control_unit
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  control_unit_if.slave bus
);

  ctrl_t ctrl;

  // Stateless block: clk is carried only so every pipeline unit shares one port shape.
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    ctrl = NOP_CTRL;
    if (!rst && !bus.stall_FETCH) begin
      case (bus.i_type)
        OP_RTYPE: begin
          case (bus.function_code)
            FN_ADD, FN_ADDU: begin ctrl.alu_op = ALU_ADD;  ctrl.regwrite = 1'b1; end
            FN_SUB, FN_SUBU: begin ctrl.alu_op = ALU_SUB;  ctrl.regwrite = 1'b1; end
            FN_AND:          begin ctrl.alu_op = ALU_AND;  ctrl.regwrite = 1'b1; end
            FN_OR:           begin ctrl.alu_op = ALU_OR;   ctrl.regwrite = 1'b1; end
            FN_XOR:          begin ctrl.alu_op = ALU_XOR;  ctrl.regwrite = 1'b1; end
            FN_NOR:          begin ctrl.alu_op = ALU_NOR;  ctrl.regwrite = 1'b1; end
            FN_SLT:          begin ctrl.alu_op = ALU_SLT;  ctrl.regwrite = 1'b1; end
            FN_SLTU:         begin ctrl.alu_op = ALU_SLTU; ctrl.regwrite = 1'b1; end
            FN_SLL: begin
              ctrl.alu_op   = ALU_SLL;
              ctrl.shamt    = bus.shamt;
              ctrl.regwrite = 1'b1;
            end
            FN_SRL: begin
              ctrl.alu_op   = ALU_SRL;
              ctrl.shamt    = bus.shamt;
              ctrl.regwrite = 1'b1;
            end
            FN_SRA: begin
              ctrl.alu_op   = ALU_SRA;
              ctrl.shamt    = bus.shamt;
              ctrl.regwrite = 1'b1;
            end
            FN_MULT:  begin ctrl.alu_op = ALU_MULT;  ctrl.enhilo = 1'b1; end
            FN_MULTU: begin ctrl.alu_op = ALU_MULTU; ctrl.enhilo = 1'b1; end
            FN_MFHI:  begin ctrl.regsel = REGSEL_HI; ctrl.regwrite = 1'b1; end
            FN_MFLO:  begin ctrl.regsel = REGSEL_LO; ctrl.regwrite = 1'b1; end
            default: ctrl = NOP_CTRL;
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          ctrl.alu_op = ALU_ADD;  ctrl.alu_src = SRC_SIMM;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        OP_SLTI: begin
          ctrl.alu_op = ALU_SLT;  ctrl.alu_src = SRC_SIMM;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        OP_SLTIU: begin
          ctrl.alu_op = ALU_SLTU; ctrl.alu_src = SRC_SIMM;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        OP_ANDI: begin
          ctrl.alu_op = ALU_AND;  ctrl.alu_src = SRC_ZIMM;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        OP_ORI: begin
          ctrl.alu_op = ALU_OR;   ctrl.alu_src = SRC_ZIMM;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        OP_XORI: begin
          ctrl.alu_op = ALU_XOR;  ctrl.alu_src = SRC_ZIMM;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        // lui is the zero-extended immediate shifted left by a fixed 16.
        OP_LUI: begin
          ctrl.alu_op = ALU_SLL;  ctrl.alu_src = SRC_ZIMM;
          ctrl.shamt  = LUI_SHAMT;
          ctrl.regwrite = 1'b1;   ctrl.rdrt = 1'b1;
        end
        OP_GPIO: begin
          case (bus.function_code)
            FN_GPIO_IN: begin
              ctrl.gpio_in  = 1'b1;
              ctrl.regwrite = 1'b1;
              ctrl.rdrt     = 1'b1;
            end
            FN_GPIO_OUT: ctrl.gpio_out = 1'b1;
            default:     ctrl = NOP_CTRL;
          endcase
        end
        default: ctrl = NOP_CTRL;
      endcase
    end
  end

  assign bus.alu_op      = ctrl.alu_op;
  assign bus.shamt_EX    = ctrl.shamt;
  assign bus.enhilo_EX   = ctrl.enhilo;
  assign bus.regsel_EX   = ctrl.regsel;
  assign bus.regwrite_EX = ctrl.regwrite;
  assign bus.rdrt_EX     = ctrl.rdrt;
  assign bus.memwrite_EX = ctrl.memwrite;
  assign bus.alu_src_EX  = ctrl.alu_src;
  assign bus.GPIO_OUT    = ctrl.gpio_out;
  assign bus.GPIO_IN     = ctrl.gpio_in;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit: vector table, sequences, random vs model
module tb_control_unit;

  logic clk;
  logic rst;
  control_unit_if cu_if ();

  control_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (cu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {alu_op, shamt, enhilo, regsel, regwrite, rdrt, memwrite, alu_src, gpio_out, gpio_in}
  function automatic logic [18:0] pk(logic [3:0] a, logic [4:0] s, logic eh, logic [1:0] rs,
                                     logic we, logic rd, logic [1:0] src, logic go, logic gi);
    return {a, s, eh, rs, we, rd, 1'b0, src, go, gi};
  endfunction

  logic [18:0] nop_v;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         any_fn;
    logic [3:0] alu;
    bit         sh_instr;
    logic [4:0] sh_const;
    logic [1:0] src;
    bit         rdrt;
    bit         we;
    bit         eh;
    logic [1:0] rs;
    bit         gi;
    bit         go;
  } row_t;

  row_t rows[$];

  task automatic add_row(logic [5:0] op, logic [5:0] fn, bit any_fn, logic [3:0] alu, bit sh_instr,
                         logic [4:0] sh_const, logic [1:0] src, bit rdrt, bit we, bit eh,
                         logic [1:0] rs, bit gi, bit go);
    row_t r;
    r.op = op; r.fn = fn; r.any_fn = any_fn; r.alu = alu; r.sh_instr = sh_instr;
    r.sh_const = sh_const; r.src = src; r.rdrt = rdrt; r.we = we; r.eh = eh;
    r.rs = rs; r.gi = gi; r.go = go;
    rows.push_back(r);
  endtask

  // Instruction-set table transcribed from the ISA description; lookup is first match.
  task automatic build_model();
    add_row(6'd0, 6'b100000, 0, 4'h4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100001, 0, 4'h4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100010, 0, 4'h5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100011, 0, 4'h5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100100, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100101, 0, 4'h1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100110, 0, 4'h3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b100111, 0, 4'h2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b101010, 0, 4'hC, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b101011, 0, 4'hD, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b000000, 0, 4'h8, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b000010, 0, 4'h9, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b000011, 0, 4'hA, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add_row(6'd0, 6'b011000, 0, 4'h6, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_row(6'd0, 6'b011001, 0, 4'h7, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_row(6'd0, 6'b010000, 0, 4'h4, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add_row(6'd0, 6'b010010, 0, 4'h4, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    add_row(6'b001000, 0, 1, 4'h4, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add_row(6'b001001, 0, 1, 4'h4, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add_row(6'b001010, 0, 1, 4'hC, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add_row(6'b001011, 0, 1, 4'hD, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add_row(6'b001100, 0, 1, 4'h0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    add_row(6'b001101, 0, 1, 4'h1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    add_row(6'b001110, 0, 1, 4'h3, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    add_row(6'b001111, 0, 1, 4'h8, 0, 16, 2, 1, 1, 0, 0, 0, 0);
    add_row(6'b010000, 6'b000000, 0, 4'h4, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add_row(6'b010000, 6'b000001, 0, 4'h4, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [18:0] model(logic [5:0] op, logic [4:0] sh, logic [5:0] fn,
                                        logic stall, logic r);
    if (stall || r) return nop_v;
    foreach (rows[i]) begin
      if (rows[i].op == op && (rows[i].any_fn || rows[i].fn == fn))
        return pk(rows[i].alu, rows[i].sh_instr ? sh : rows[i].sh_const, rows[i].eh, rows[i].rs,
                  rows[i].we, rows[i].rdrt, rows[i].src, rows[i].go, rows[i].gi);
    end
    return nop_v;
  endfunction

  function automatic logic [18:0] dut_out();
    return {cu_if.alu_op, cu_if.shamt_EX, cu_if.enhilo_EX, cu_if.regsel_EX, cu_if.regwrite_EX,
            cu_if.rdrt_EX, cu_if.memwrite_EX, cu_if.alu_src_EX, cu_if.GPIO_OUT, cu_if.GPIO_IN};
  endfunction

  task automatic check(string name, logic [18:0] want);
    logic [18:0] got;
    got = dut_out();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%05h want=%05h (op=%b fn=%b sh=%0d stall=%b rst=%b)", name, got, want,
               cu_if.i_type, cu_if.function_code, cu_if.shamt, cu_if.stall_FETCH, rst);
    end
  endtask

  task automatic apply(logic [5:0] op, logic [4:0] sh, logic [5:0] fn, logic stall);
    @(negedge clk);
    cu_if.i_type        = op;
    cu_if.shamt         = sh;
    cu_if.function_code = fn;
    cu_if.stall_FETCH   = stall;
    #2;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic        stall;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(string name, logic [5:0] op, logic [4:0] sh, logic [5:0] fn, logic stall,
                         logic [18:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.sh = sh; v.fn = fn; v.stall = stall; v.exp = exp;
    vecs.push_back(v);
  endtask

  logic [5:0] legal_fn[8];

  initial begin
    nop_v = pk(4'h4, 0, 0, 0, 0, 0, 0, 0, 0);
    build_model();

    add_vec("add",         6'd0,      5'd7,  6'b100000, 0, pk(4'h4, 0,  0, 0, 1, 0, 0, 0, 0));
    add_vec("subu",        6'd0,      5'd0,  6'b100011, 0, pk(4'h5, 0,  0, 0, 1, 0, 0, 0, 0));
    add_vec("nor",         6'd0,      5'd0,  6'b100111, 0, pk(4'h2, 0,  0, 0, 1, 0, 0, 0, 0));
    add_vec("sra5",        6'd0,      5'd5,  6'b000011, 0, pk(4'hA, 5,  0, 0, 1, 0, 0, 0, 0));
    add_vec("srl31",       6'd0,      5'd31, 6'b000010, 0, pk(4'h9, 31, 0, 0, 1, 0, 0, 0, 0));
    add_vec("word0_sll",   6'd0,      5'd0,  6'b000000, 0, pk(4'h8, 0,  0, 0, 1, 0, 0, 0, 0));
    add_vec("lui",         6'b001111, 5'd3,  6'b101010, 0, pk(4'h8, 16, 0, 0, 1, 1, 2, 0, 0));
    add_vec("addi",        6'b001000, 5'd0,  6'b000000, 0, pk(4'h4, 0,  0, 0, 1, 1, 1, 0, 0));
    add_vec("andi",        6'b001100, 5'd0,  6'b000000, 0, pk(4'h0, 0,  0, 0, 1, 1, 2, 0, 0));
    add_vec("sltiu",       6'b001011, 5'd0,  6'b000000, 0, pk(4'hD, 0,  0, 0, 1, 1, 1, 0, 0));
    add_vec("multu",       6'd0,      5'd0,  6'b011001, 0, pk(4'h7, 0,  1, 0, 0, 0, 0, 0, 0));
    add_vec("gpio_in",     6'b010000, 5'd0,  6'b000000, 0, pk(4'h4, 0,  0, 0, 1, 1, 0, 0, 1));
    add_vec("gpio_out",    6'b010000, 5'd0,  6'b000001, 0, pk(4'h4, 0,  0, 0, 0, 0, 0, 1, 0));
    add_vec("gpio_bad_fn", 6'b010000, 5'd0,  6'b000010, 0, nop_v);
    add_vec("illegal_op",  6'b111111, 5'd9,  6'b100000, 0, nop_v);
    add_vec("illegal_fn",  6'd0,      5'd0,  6'b111111, 0, nop_v);
    add_vec("stall_add",   6'd0,      5'd0,  6'b100000, 1, nop_v);
    add_vec("stall_lui",   6'b001111, 5'd0,  6'b000000, 1, nop_v);

    legal_fn = '{6'b100000, 6'b000011, 6'b011000, 6'b010000, 6'b010010, 6'b101011, 6'b000000,
                 6'b000001};

    rst = 1'b1;
    cu_if.i_type = 6'd0; cu_if.shamt = 5'd0; cu_if.function_code = 6'b100000;
    cu_if.stall_FETCH = 1'b0;
    #3;
    check("reset_nop", nop_v);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].sh, vecs[i].fn, vecs[i].stall);
      check(vecs[i].name, vecs[i].exp);
    end

    apply(6'd0, 5'd5, 6'b000011, 0);
    check("seq_sra", pk(4'hA, 5, 0, 0, 1, 0, 0, 0, 0));
    apply(6'b001111, 5'd5, 6'b000011, 0);
    check("seq_lui", pk(4'h8, 16, 0, 0, 1, 1, 2, 0, 0));

    apply(6'd0, 5'd0, 6'b011000, 0);
    check("seq_mult", pk(4'h6, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(6'd0, 5'd0, 6'b010000, 0);
    check("seq_mfhi", pk(4'h4, 0, 0, 1, 1, 0, 0, 0, 0));
    apply(6'd0, 5'd0, 6'b010010, 0);
    check("seq_mflo", pk(4'h4, 0, 0, 2, 1, 0, 0, 0, 0));

    // Asynchronous reset asserted and released between clock edges.
    apply(6'd0, 5'd0, 6'b100000, 0);
    check("pre_rst_add", pk(4'h4, 0, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_add", nop_v);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_add", pk(4'h4, 0, 0, 0, 1, 0, 0, 0, 0));

    for (int n = 0; n < 2000; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] sh;
      logic       st;
      case ($urandom_range(0, 3))
        0: op = 6'd0;
        1: op = 6'b010000;
        2: op = 6'($urandom_range(8, 15));
        default: op = 6'($urandom_range(0, 63));
      endcase
      fn = ($urandom_range(0, 1) == 1) ? legal_fn[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
      sh = 5'($urandom_range(0, 31));
      st = ($urandom_range(0, 7) == 0);
      apply(op, sh, fn, st);
      check("random", model(op, sh, fn, st, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
